bit_serial_logic_32: RTL
========================

// Module: bit_serial_logic_32
// PURPOSE
//   Multi-cycle, bit-serial counterpart of the parallel per-bit logic gates.
//   Accepts two WIDTH-bit operands and an opcode (AND/OR/XOR/NOR), then
//   produces STEP result bits per clock, LSB first. Returns the full result
//   over a valid/ready handshake. Serves the low-area ALU variant of the CPU.
// PARAMETERS
//   WIDTH  32  operand and result width
//   STEP   1   bits processed per cycle; must divide WIDTH (1,2,4,8,16,32)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operands/opcode valid
//   in_ready   out  1      block can accept operands (IDLE only)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   op         in   2      00 AND, 01 OR, 10 XOR, 11 NOR
//   out_valid  out  1      result valid, held until accepted
//   out_ready  in   1      consumer accepts result
//   result     out  WIDTH  logic result
//   zero       out  1      result==0 (only with BSL_ZERO_FLAG_EN)
// BEHAVIOUR
//   Reset (rst=1 at clock edge): state=IDLE, in_ready=1, out_valid=0,
//     result=0, zero=0, counter=0, operand shift regs=0. Aborts any operation.
//   FSM IDLE -> RUN -> DONE -> IDLE:
//     IDLE: in_ready=1. in_valid&in_ready at edge: latch a,b,op; cnt=WIDTH/STEP; ->RUN.
//     RUN: in_ready=0. Each cycle: apply op to low STEP bits of sa,sb;
//       shift sa,sb right by STEP; shift result right by STEP with the
//       new bits entering at the top. cnt-=1; at cnt==1 -> DONE.
//     DONE: out_valid=1, result stable. out_ready=1 at edge -> IDLE.
//   Latency: accept at edge N -> out_valid=1 after edge N+WIDTH/STEP.
//   Throughput: one op per WIDTH/STEP+2 cycles minimum.
//   in_valid in RUN/DONE is ignored (in_ready=0). Sampling is not stored.
//   out_ready outside DONE has no effect. out_valid is never raised in IDLE.
//   result holds its last value in IDLE. Changing op/a/b after accept has no effect.
//   NOR = ~(a|b) per bit. No carries; bits are independent.
//   Counter width is $clog2(WIDTH/STEP)+1. Must not wrap.
//   STEP==WIDTH: single RUN cycle. Legal.
// CONFIGURATION
//   BSL_ZERO_FLAG_EN defined: zero is a port.
//     zero=1 in DONE iff result==0. Computed from running OR of produced bits.
//     Cleared on accept of a new operation and on reset.
//   BSL_ZERO_FLAG_EN undefined: zero port and its logic are absent.
// STRUCTURE
//   Shared package (cpu_alu_pkg): opcode localparams OP_AND/OP_OR/OP_XOR/OP_NOR,
//     FSM state encodings S_IDLE/S_RUN/S_DONE.
//   Sub-module bsl_slice (combinational, STEP-bit): op, a_bits, b_bits -> r_bits.
//     Instantiated once. Holds the per-bit gate array.
// TESTING
//   1. WIDTH=32,STEP=1: a=F0F0_F0F0,b=0F0F_0F0F,op=OR -> out_valid after 32
//      cycles, result=FFFF_FFFF.
//   2. op=AND with the same operands -> result=0000_0000.
//      zero=1 when BSL_ZERO_FLAG_EN is defined.
//   3. op=XOR a=1234_5678,b=FFFF_0000 -> EDCB_5678.
//      op=NOR a=0,b=0 -> FFFF_FFFF.
//   4. in_valid held high during RUN with a=DEAD_BEEF -> ignored.
//      The first result is unchanged. in_ready=0 until return to IDLE.
//   5. DONE with out_ready=0 for 5 cycles -> out_valid and result stay stable.
//      out_ready=1 -> IDLE on the next edge.
//   6. rst=1 at RUN cycle 10 -> next edge gives IDLE, out_valid=0, result=0.
//      A new op then completes correctly. Repeat cases 1-3 with STEP=4:
//      latency is 8 cycles.

Source files
------------

// File: rtl/cpu_alu_pkg.sv
// cpu_alu_pkg
//   Definitions shared by the low-area ALU blocks: the logic opcode
//   encodings and the state encoding of the bit-serial sequencer.
package cpu_alu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bsl_slice.sv
// bsl_slice
//   Combinational STEP-bit gate array. Every bit is independent; there is
//   no carry between bit positions.
// Ports
//   op      in  2     opcode (AND/OR/XOR/NOR)
//   a_bits  in  STEP  operand A slice
//   b_bits  in  STEP  operand B slice
//   r_bits  out STEP  result slice
module bsl_slice
  import cpu_alu_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic [1:0]      op,
  input  logic [STEP-1:0] a_bits,
  input  logic [STEP-1:0] b_bits,
  output logic [STEP-1:0] r_bits
);

  // Select one of the four per-bit gate functions.
  always_comb begin
    r_bits = '0;
    case (op)
      OP_AND:  r_bits = a_bits & b_bits;
      OP_OR:   r_bits = a_bits | b_bits;
      OP_XOR:  r_bits = a_bits ^ b_bits;
      default: r_bits = ~(a_bits | b_bits);
    endcase
  end

endmodule

// File: rtl/bit_serial_logic_32.sv
// bit_serial_logic_32
//   Bit-serial logic unit: STEP result bits per clock, LSB first, with a
//   valid/ready handshake on both the operand and result sides.
// Optional feature macro: BSL_ZERO_FLAG_EN adds the zero output.
// Ports
//   clk        in  1      clock, rising edge
//   rst        in  1      synchronous active-high reset
//   in_valid   in  1      operands/opcode valid
//   in_ready   out 1      high in IDLE only
//   a, b       in  WIDTH  operands
//   op         in  2      00 AND, 01 OR, 10 XOR, 11 NOR
//   out_valid  out 1      result valid, held until out_ready
//   out_ready  in  1      consumer accepts result
//   result     out WIDTH  logic result
//   zero       out 1      result==0 in DONE (BSL_ZERO_FLAG_EN only)
module bit_serial_logic_32
  import cpu_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef BSL_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int NSTEPS = WIDTH / STEP;
  localparam int CW     = $clog2(NSTEPS) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(NSTEPS);

  state_t          state, state_nxt;
  logic [WIDTH-1:0] sa, sb, res, res_next;
  logic [1:0]       op_r;
  logic [CW-1:0]    cnt;
  logic [STEP-1:0]  r_bits;
  logic             accept;

  assign accept = (state == S_IDLE) && in_valid;
  assign result = res;

  bsl_slice #(.STEP(STEP)) u_slice (
    .op     (op_r),
    .a_bits (sa[STEP-1:0]),
    .b_bits (sb[STEP-1:0]),
    .r_bits (r_bits)
  );

  // New bits enter at the top so that after NSTEPS shifts the first
  // produced slice has arrived at the LSB position.
  generate
    if (STEP == WIDTH) begin : g_full
      assign res_next = r_bits;
    end else begin : g_part
      assign res_next = {r_bits, res[WIDTH-1:STEP]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs. The last RUN cycle is the one that
  // sees cnt==1, so DONE is entered exactly NSTEPS edges after accept.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (cnt == CW'(1)) state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operands are captured on accept and consumed STEP bits per
  // cycle; result is only touched in RUN so it holds in IDLE and DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      res  <= '0;
      op_r <= OP_AND;
      cnt  <= '0;
    end else if (accept) begin
      sa   <= a;
      sb   <= b;
      op_r <= op;
      cnt  <= CNT_LOAD;
    end else if (state == S_RUN) begin
      sa  <= sa >> STEP;
      sb  <= sb >> STEP;
      res <= res_next;
      cnt <= cnt - 1'b1;
    end
  end

`ifdef BSL_ZERO_FLAG_EN
  logic any_one;

  // Running OR of every produced bit; cleared on accept.
  always_ff @(posedge clk) begin
    if (rst)                  any_one <= 1'b0;
    else if (accept)          any_one <= 1'b0;
    else if (state == S_RUN)  any_one <= any_one | (|r_bits);
  end

  assign zero = (state == S_DONE) && !any_one;
`endif

endmodule
